pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
- Multi-channel programmable pulse generator that drives periodic strobes for the LVDS/SPI front end and DMA test triggers.
- Each channel has its own on/off times in clock cycles, its own enable, and an optional finite burst count, all configurable at runtime.
- Register values are taken on period boundaries, so reconfiguration is glitch-free.
- Sits in the fabric clock domain, next to the DMA control logic.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16).
- CNT_W, 32, width of the on/off time counters, in cycles.
- BURST_W, 16, width of the burst-count register.
- CLK_FREQ_MHz, 100, clock frequency; used only to compute reset defaults.
- DEF_TON_us, 50, reset on-time in microseconds.
- DEF_TOFF_us, 50, reset off-time in microseconds.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable, level-sensitive.
- cfg_we  in  1  configuration write strobe, one cycle wide.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of the write.
- cfg_ton  in  CNT_W  on-time in cycles.
- cfg_toff  in  CNT_W  off-time in cycles.
- cfg_burst  in  BURST_W  number of periods per run; 0 means continuous.
- pulse_out  out  NUM_CH  registered channel outputs.
- busy  out  NUM_CH  high while the channel is not IDLE.
- done  out  NUM_CH  one-cycle pulse when a finite burst completes.

Behaviour:
- Reset values:
  - pulse_out=0, busy=0, done=0, every channel IDLE.
  - Shadow ton = DEF_TON_us*CLK_FREQ_MHz and shadow toff = DEF_TOFF_us*CLK_FREQ_MHz, truncated to CNT_W.
  - Shadow burst = 0.
- Config writes:
  - When cfg_we=1, the shadow ton/toff/burst of channel cfg_ch update on the next edge.
  - If cfg_ch >= NUM_CH, the write is ignored.
  - Shadows are copied into the active registers only on entry to ON from IDLE or OFF. A running period is never altered.
- Per-channel states: IDLE, ON, OFF.
  - IDLE: if ch_en=1 and (ton+toff)!=0, load active registers, load remaining=burst, and go to ON (or to OFF if ton=0).
  - ON: pulse_out=1 for exactly ton cycles, then go to OFF. If toff=0, skip OFF and start the next period directly.
  - OFF: pulse_out=0 for exactly toff cycles. At the end of OFF:
    - burst=0: start the next period (reload shadows).
    - remaining>1: decrement remaining and start the next period.
    - remaining=1: pulse done for one cycle, go to IDLE.
- Timing and duty:
  - If ch_en is sampled high in IDLE at edge N, pulse_out is high from edge N+1.
  - Period is exactly ton+toff cycles with no extra cycle.
  - toff=0 gives a constant high output; ton=0 gives a constant low output while busy.
- Boundary conditions:
  - ton+toff=0: the channel stays IDLE, busy=0, and does not start.
  - ch_en falling in any state: next edge goes to IDLE, pulse_out=0, busy=0, no done pulse.
  - ch_en still high after done: the channel restarts on the following cycle with a fresh burst.
  - Counters compare against value-1 and never wrap. Maximum period is (2^CNT_W-1)*2 cycles.
- Reset asserted mid-operation: all outputs go to 0 immediately, and shadows return to their defaults.
- Channels are fully independent. A config write to a channel while it runs only affects that channel's next period.

Optional Feature:
- Macro: PULSE_GEN_PHASE_EN
- Defined:
  - Adds input cfg_phase[CNT_W], written alongside the other cfg_* fields.
  - Adds a PHASE state between IDLE and the first ON, holding pulse_out=0 for phase cycles. phase=0 skips it.
  - The phase is applied only on start from IDLE, never between burst periods.
  - busy=1 during PHASE.
- Undefined: no cfg_phase port, no PHASE state, and the first ON follows IDLE directly.

Decomposition:
- Package pulse_gen_pkg:
  - state enum (IDLE, ON, OFF, PHASE).
  - default CNT_W and BURST_W localparams.
  - function us_to_cycles(us, mhz).
- Sub-module pulse_gen_ch: one channel FSM with its shadow/active registers and counters.
- Top pulse_gen_multi: decodes cfg_ch into per-channel write enables and generates NUM_CH instances.

Test Plan:
- Reset, then ch_en[0]=1 with defaults at 100 MHz -> pulse_out[0] high 5000 cycles, low 5000 cycles, repeating; first rise 1 cycle after enable.
- Write ch1 ton=3, toff=2, burst=4, then ch_en[1]=1 -> pattern 11100 repeated exactly 4 times; done[1] pulses once on the last OFF cycle's following edge; busy[1] falls the same edge.
- Ch2 running ton=10, toff=10; write ton=2 mid-ON -> current period keeps 10/10, next period is 2/10.
- ton=0 and toff=0 on ch3 with ch_en=1 -> busy stays 0, pulse_out stays 0. Then toff=0, ton=5 -> constant high.
- Drop ch_en[0] mid-ON, and separately assert rst mid-OFF -> pulse_out 0 next edge, no done pulse; after rst, defaults are restored (5000/5000).
- With PULSE_GEN_PHASE_EN: ch0 and ch1 both ton=4, toff=4; ch1 phase=2; enable both on the same edge -> ch1 rising edge is 2 cycles after ch0's, period stays 8 on both.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types, defaults and helpers for the multi-channel pulse generator.
// Optional phase-offset support is enabled by defining PULSE_GEN_PHASE_EN.
package pulse_gen_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int BURST_W_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;
    localparam logic [1:0] ST_PHASE = 2'd3;

    function automatic logic [63:0] us_to_cycles(
        input int unsigned us,
        input int unsigned mhz
    );
        return 64'(us) * 64'(mhz);
    endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse channel: shadow/active registers, ON/OFF FSM and burst counter.
// With PULSE_GEN_PHASE_EN a start-up PHASE delay precedes the first period.
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter int               BURST_W  = BURST_W_DEF,
    parameter logic [CNT_W-1:0] DEF_TON  = '0,
    parameter logic [CNT_W-1:0] DEF_TOFF = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               we,
    input  logic [CNT_W-1:0]   ton,
    input  logic [CNT_W-1:0]   toff,
`ifdef PULSE_GEN_PHASE_EN
    input  logic [CNT_W-1:0]   phase,
`endif
    input  logic [BURST_W-1:0] burst,
    output logic               pulse,
    output logic               busy,
    output logic               done
);

    logic [CNT_W-1:0]   sh_ton;
    logic [CNT_W-1:0]   sh_toff;
    logic [BURST_W-1:0] sh_burst;
    logic [CNT_W-1:0]   act_ton;
    logic [CNT_W-1:0]   act_toff;
    logic [BURST_W-1:0] act_burst;
    logic [BURST_W-1:0] rem;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         state;

    logic on_last;
    logic off_last;
    logic eop;
    logic more;
    logic sh_ok;
    logic launch;

`ifdef PULSE_GEN_PHASE_EN
    logic [CNT_W-1:0] sh_phase;
    logic [CNT_W-1:0] act_phase;
    logic             ph_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_ton   <= DEF_TON;
            sh_toff  <= DEF_TOFF;
            sh_burst <= '0;
`ifdef PULSE_GEN_PHASE_EN
            sh_phase <= '0;
`endif
        end else if (we) begin
            sh_ton   <= ton;
            sh_toff  <= toff;
            sh_burst <= burst;
`ifdef PULSE_GEN_PHASE_EN
            sh_phase <= phase;
`endif
        end
    end

    // ON/OFF are entered only with a nonzero limit, so limit-1 never wraps
    assign on_last  = (state == ST_ON) && (cnt == act_ton - CNT_W'(1));
    assign off_last = (state == ST_OFF) && (cnt == act_toff - CNT_W'(1));
    assign eop      = off_last || (on_last && (act_toff == '0));
    assign more     = (act_burst == '0) || (rem > BURST_W'(1));
    assign sh_ok    = (sh_ton != '0) || (sh_toff != '0);
    assign launch   = (state == ST_IDLE) && sh_ok;

`ifdef PULSE_GEN_PHASE_EN
    assign ph_last = (state == ST_PHASE) && (cnt == act_phase - CNT_W'(1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            act_ton   <= '0;
            act_toff  <= '0;
            act_burst <= '0;
            rem       <= '0;
            cnt       <= '0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PULSE_GEN_PHASE_EN
            act_phase <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (!en) begin
                state <= ST_IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
                busy  <= 1'b0;
            end else if (eop && !more) begin
                state <= ST_IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
`ifdef PULSE_GEN_PHASE_EN
            end else if (launch && (sh_phase != '0)) begin
                act_ton   <= sh_ton;
                act_toff  <= sh_toff;
                act_burst <= sh_burst;
                act_phase <= sh_phase;
                rem       <= sh_burst;
                cnt       <= '0;
                state     <= ST_PHASE;
                pulse     <= 1'b0;
                busy      <= 1'b1;
`endif
            end else if (launch || eop) begin
                // period boundary: shadows become the active period
                act_ton  <= sh_ton;
                act_toff <= sh_toff;
                cnt      <= '0;
                if (launch) begin
                    act_burst <= sh_burst;
                    rem       <= sh_burst;
                end else if (act_burst != '0) begin
                    rem <= rem - BURST_W'(1);
                end
                if (!sh_ok) begin
                    state <= ST_IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                end else if (sh_ton != '0) begin
                    state <= ST_ON;
                    pulse <= 1'b1;
                    busy  <= 1'b1;
                end else begin
                    state <= ST_OFF;
                    pulse <= 1'b0;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_ON: begin
                        if (on_last) begin
                            state <= ST_OFF;
                            cnt   <= '0;
                            pulse <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_OFF: cnt <= cnt + CNT_W'(1);
`ifdef PULSE_GEN_PHASE_EN
                    ST_PHASE: begin
                        if (ph_last) begin
                            cnt <= '0;
                            if (act_ton != '0) begin
                                state <= ST_ON;
                                pulse <= 1'b1;
                            end else begin
                                state <= ST_OFF;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: decodes config writes, instances channels.
// Define PULSE_GEN_PHASE_EN to add the cfg_phase start-up offset.
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int BURST_W      = BURST_W_DEF,
    parameter int CLK_FREQ_MHz = 100,
    parameter int DEF_TON_us   = 50,
    parameter int DEF_TOFF_us  = 50,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_ton,
    input  logic [CNT_W-1:0]   cfg_toff,
    input  logic [BURST_W-1:0] cfg_burst,
`ifdef PULSE_GEN_PHASE_EN
    input  logic [CNT_W-1:0]   cfg_phase,
`endif
    output logic [NUM_CH-1:0]  pulse_out,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  done
);

    localparam logic [CNT_W-1:0] DEF_TON =
        CNT_W'(us_to_cycles(DEF_TON_us, CLK_FREQ_MHz));
    localparam logic [CNT_W-1:0] DEF_TOFF =
        CNT_W'(us_to_cycles(DEF_TOFF_us, CLK_FREQ_MHz));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we;

        // out-of-range channel numbers match no instance and are dropped
        assign we = cfg_we && (cfg_ch == CH_W'(i));

        pulse_gen_ch #(
            .CNT_W    (CNT_W),
            .BURST_W  (BURST_W),
            .DEF_TON  (DEF_TON),
            .DEF_TOFF (DEF_TOFF)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (ch_en[i]),
            .we    (we),
            .ton   (cfg_ton),
            .toff  (cfg_toff),
`ifdef PULSE_GEN_PHASE_EN
            .phase (cfg_phase),
`endif
            .burst (cfg_burst),
            .pulse (pulse_out[i]),
            .busy  (busy[i]),
            .done  (done[i])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed self-checking bench for pulse_gen_multi.
// Adds a phase-offset scenario when PULSE_GEN_PHASE_EN is defined.
module tb_pulse_gen_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_en;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_ton;
    logic [31:0] cfg_toff;
    logic [15:0] cfg_burst;
`ifdef PULSE_GEN_PHASE_EN
    logic [31:0] cfg_phase;
`endif
    logic [3:0]  pulse_out;
    logic [3:0]  busy;
    logic [3:0]  done;

    int n_checks = 0;
    int n_errors = 0;
    int dcnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    pulse_gen_multi u_dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_ton   (cfg_ton),
        .cfg_toff  (cfg_toff),
        .cfg_burst (cfg_burst),
`ifdef PULSE_GEN_PHASE_EN
        .cfg_phase (cfg_phase),
`endif
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (done[i]) dcnt[i]++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int unsigned t_on,
                             input int unsigned t_off, input int unsigned b);
        cfg_ch    = 2'(ch);
        cfg_ton   = t_on;
        cfg_toff  = t_off;
        cfg_burst = 16'(b);
        cfg_we    = 1'b1;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    logic [19:0] pat;
    logic [19:0] pat_exp;
    logic [33:0] w;
    logic [33:0] w_exp;
    logic        all_busy;
    int          highs;

    initial begin
        rst = 1'b1;
        ch_en = '0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_ton = '0;
        cfg_toff = '0;
        cfg_burst = '0;
`ifdef PULSE_GEN_PHASE_EN
        cfg_phase = '0;
`endif
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_pulse", 64'(pulse_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);

        // ch0 defaults: 5000 high / 5000 low
        ch_en = 4'b0001;
        tick(1);
        check("def_rise", 64'(pulse_out[0]), 64'h1);
        check("def_busy", 64'(busy[0]), 64'h1);
        tick(4999);
        check("def_on_end", 64'(pulse_out[0]), 64'h1);
        tick(1);
        check("def_off", 64'(pulse_out[0]), 64'h0);
        tick(4999);
        check("def_off_end", 64'(pulse_out[0]), 64'h0);
        tick(1);
        check("def_rise2", 64'(pulse_out[0]), 64'h1);
        tick(10);
        ch_en[0] = 1'b0;
        tick(1);
        check("drop_pulse", 64'(pulse_out[0]), 64'h0);
        check("drop_busy", 64'(busy[0]), 64'h0);
        check("drop_nodone", 64'(dcnt[0]), 64'h0);

        // ch1 burst of four 11100 periods
        cfg_write(1, 3, 2, 4);
        ch_en[1] = 1'b1;
        all_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            pat[i] = pulse_out[1];
            pat_exp[i] = (i % 5) < 3;
            all_busy &= busy[1];
        end
        check("burst_pat", 64'(pat), 64'(pat_exp));
        check("burst_busy", 64'(all_busy), 64'h1);
        check("burst_early", 64'(dcnt[1]), 64'h0);
        tick(1);
        check("burst_done", 64'(done[1]), 64'h1);
        check("burst_idle", 64'(busy[1]), 64'h0);
        tick(1);
        check("done_1cyc", 64'(done[1]), 64'h0);
        check("restart", 64'(pulse_out[1]), 64'h1);
        check("done_once", 64'(dcnt[1]), 64'h1);
        ch_en[1] = 1'b0;
        tick(1);

        // ch2: ton rewritten mid-ON takes effect next period
        cfg_write(2, 10, 10, 0);
        ch_en[2] = 1'b1;
        tick(1);
        w[0] = pulse_out[2];
        cfg_ch = 2'd2;
        cfg_ton = 2;
        cfg_toff = 10;
        cfg_burst = '0;
        cfg_we = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        w[1] = pulse_out[2];
        for (int i = 2; i < 34; i++) begin
            tick(1);
            w[i] = pulse_out[2];
        end
        for (int i = 0; i < 34; i++)
            w_exp[i] = (i < 10) || (i >= 20 && i < 22) || (i >= 32);
        check("reconfig", 64'(w), 64'(w_exp));
        ch_en[2] = 1'b0;
        tick(1);

        // ch3: zero period never starts; toff=0 holds high
        cfg_write(3, 0, 0, 0);
        ch_en[3] = 1'b1;
        tick(3);
        check("zero_busy", 64'(busy[3]), 64'h0);
        check("zero_pulse", 64'(pulse_out[3]), 64'h0);
        cfg_write(3, 5, 0, 0);
        tick(1);
        check("const_rise", 64'(pulse_out[3]), 64'h1);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (pulse_out[3] && busy[3]) highs++;
        end
        check("const_high", 64'(highs), 64'd12);
        ch_en[3] = 1'b0;
        tick(1);

        // reset mid-OFF restores defaults
        cfg_write(0, 4, 6, 2);
        ch_en[0] = 1'b1;
        tick(1);
        check("r_rise", 64'(pulse_out[0]), 64'h1);
        tick(5);
        check("r_off", 64'(pulse_out[0]), 64'h0);
        check("r_offbusy", 64'(busy[0]), 64'h1);
        rst = 1'b1;
        #1;
        check("r_async_busy", 64'(busy), 64'h0);
        check("r_async_pulse", 64'(pulse_out), 64'h0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("r_def_rise", 64'(pulse_out[0]), 64'h1);
        tick(4999);
        check("r_def_on", 64'(pulse_out[0]), 64'h1);
        tick(1);
        check("r_def_off", 64'(pulse_out[0]), 64'h0);
        check("r_nodone", 64'(dcnt[0]), 64'h0);
        ch_en = '0;
        tick(1);

`ifdef PULSE_GEN_PHASE_EN
        cfg_phase = 0;
        cfg_write(0, 4, 4, 0);
        cfg_phase = 2;
        cfg_write(1, 4, 4, 0);
        cfg_phase = 0;
        ch_en = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            pat[i] = pulse_out[0];
            pat_exp[i] = (i % 8) < 4;
            w[i] = pulse_out[1];
            w_exp[i] = (i >= 2) && (((i - 2) % 8) < 4);
        end
        check("ph_ch0", 64'(pat), 64'(pat_exp));
        check("ph_ch1", 64'(w[19:0]), 64'(w_exp[19:0]));
        ch_en = '0;
        tick(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
